dac_dsm2_top: RTL and testbench

DAC_DSM2_TOP -- requirements
Module: dac_dsm2_top

---
 rtl/dac_dsm2_top.sv | 85 ++++++++
 tb/tb_dac_dsm2_top.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_dsm2_top.sv
// dac_dsm2_top
// Second-order, single-loop, 1-bit delta-sigma modulator (MOD2) for an audio
// DAC. Its noise transfer function is (1-z^-1)^2 and its signal transfer
// function has unity gain. The block consumes one PCM sample on every rising
// clk edge, and the top level drives clk from the 96 kHz sample strobe.
//
// Ports
//   clk    : sample clock; all state updates happen on its rising edge
//   n_rst  : asynchronous, active-low reset; clears both integrators and dout
//   din    : signed two's-complement PCM sample (DIN_W bits), read every edge
//   dout   : registered bitstream; 1 = +full-scale, 0 = -full-scale
//
// Both integrators saturate instead of wrapping. An overloaded loop (for
// example din = -F held) therefore parks at the rails and recovers cleanly
// once din returns to a stable range.

module dac_dsm2_top #(
    parameter int DIN_W = 24,
    parameter int ACC_W = 28
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic signed [DIN_W-1:0] din,
    output logic                    dout
);

    // Two guard bits hold the worst-case unsaturated sum
    // (|acc2| + |a1n| + F < 2^(ACC_W+1)).
    localparam int EXT_W = ACC_W + 2;

    localparam logic signed [EXT_W-1:0] FS =
        {{(EXT_W-DIN_W){1'b0}}, 1'b1, {(DIN_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    if (ACC_W < DIN_W + 3) begin : g_acc_w_check
        $error("dac_dsm2_top: ACC_W must be at least DIN_W+3");
    end

    logic signed [ACC_W-1:0] acc1;
    logic signed [ACC_W-1:0] acc2;
    logic signed [ACC_W-1:0] a1_sat;
    logic signed [ACC_W-1:0] a2_sat;
    logic signed [EXT_W-1:0] din_ext;
    logic signed [EXT_W-1:0] fb;
    logic signed [EXT_W-1:0] a1_raw;
    logic signed [EXT_W-1:0] a2_raw;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [EXT_W-1:0] v);
        logic signed [EXT_W-1:0] r;
        if (v > SAT_MAX)
            r = SAT_MAX;
        else if (v < SAT_MIN)
            r = SAT_MIN;
        else
            r = v;
        return r[ACC_W-1:0];
    endfunction

    always_comb begin
        din_ext = {{(EXT_W-DIN_W){din[DIN_W-1]}}, din};
        fb      = dout ? FS : -FS;
        a1_raw  = {{(EXT_W-ACC_W){acc1[ACC_W-1]}}, acc1} + din_ext - fb;
        a1_sat  = sat(a1_raw);
        // The second stage integrates the already-saturated first-stage value.
        a2_raw  = {{(EXT_W-ACC_W){acc2[ACC_W-1]}}, acc2}
                + {{(EXT_W-ACC_W){a1_sat[ACC_W-1]}}, a1_sat} - fb;
        a2_sat  = sat(a2_raw);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc1 <= '0;
            acc2 <= '0;
            dout <= 1'b0;
        end else begin
            acc1 <= a1_sat;
            acc2 <= a2_sat;
            dout <= ~a2_sat[ACC_W-1];
        end
    end

endmodule

// File: tb/tb_dac_dsm2_top.sv
module tb_dac_dsm2_top;

    localparam int     DIN_W   = 24;
    localparam int     ACC_W   = 28;
    localparam longint F       = 64'sd8388608;
    localparam longint SAT_MAX = 64'sd134217727;
    localparam longint SAT_MIN = -64'sd134217728;

    logic                    clk = 1'b0;
    logic                    n_rst = 1'b0;
    logic signed [DIN_W-1:0] din = '0;
    logic                    dout;

    int checks = 0;
    int errors = 0;

    longint m_acc1 = 0;
    longint m_acc2 = 0;
    bit     m_dout = 1'b0;

    typedef struct {
        longint din;
        bit     dout_exp;
    } vec_t;

    vec_t seq0 [16];

    dac_dsm2_top #(.DIN_W(DIN_W), .ACC_W(ACC_W)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    task automatic model_reset();
        m_acc1 = 0;
        m_acc2 = 0;
        m_dout = 1'b0;
    endtask

    // Called just after a falling edge: drive a sample, advance the model,
    // let the DUT take one rising edge, then compare at the next falling edge.
    task automatic step(input longint d);
        longint fbv;
        longint a1;
        longint a2;
        din = d[DIN_W-1:0];
        fbv = m_dout ? F : -F;
        a1 = sat(m_acc1 + d - fbv);
        a2 = sat(m_acc2 + a1 - fbv);
        m_acc1 = a1;
        m_acc2 = a2;
        m_dout = (a2 >= 0);
        @(posedge clk);
        @(negedge clk);
        check("model_dout", longint'(dout), longint'(m_dout));
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        din = '0;
        #1;
        model_reset();
        check("reset_dout", longint'(dout), 0);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic run_seq0(input string name);
        for (int i = 0; i < 16; i++) begin
            step(seq0[i].din);
            check(name, longint'(dout), longint'(seq0[i].dout_exp));
        end
    endtask

    initial begin
        longint cnt;
        longint a1v;
        longint a2v;
        longint d;
        longint sum_din;
        longint sum_fb;
        longint err;
        longint max_err;
        longint ring_din [256];
        longint ring_fb [256];
        int     idx;
        int     tries;

        // dout sequence for din = 0 after reset: 1,1,0,1,0,0,1,1 then 0,0,1,1 ...
        for (int i = 0; i < 16; i++) seq0[i].din = 0;
        seq0[0].dout_exp  = 1; seq0[1].dout_exp  = 1; seq0[2].dout_exp  = 0; seq0[3].dout_exp  = 1;
        seq0[4].dout_exp  = 0; seq0[5].dout_exp  = 0; seq0[6].dout_exp  = 1; seq0[7].dout_exp  = 1;
        seq0[8].dout_exp  = 0; seq0[9].dout_exp  = 0; seq0[10].dout_exp = 1; seq0[11].dout_exp = 1;
        seq0[12].dout_exp = 0; seq0[13].dout_exp = 0; seq0[14].dout_exp = 1; seq0[15].dout_exp = 1;

        // Power-on reset held across two rising edges.
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("por_dout", longint'(dout), 0);
        a1v = dut.acc1;
        a2v = dut.acc2;
        check("por_acc1", a1v, 0);
        check("por_acc2", a2v, 0);
        n_rst = 1'b1;
        run_seq0("seq_zero");

        // +F/2 held: density 0.75.
        do_reset();
        cnt = 0;
        repeat (4096) begin
            step(64'sh400000);
            cnt += longint'(dout);
        end
        check_range("ones_half_fs", cnt, 3070, 3074);

        // -F/4 held: density 0.375.
        do_reset();
        cnt = 0;
        repeat (4096) begin
            step(-64'sh200000);
            cnt += longint'(dout);
        end
        check_range("ones_neg_quarter_fs", cnt, 1534, 1538);

        // Positive overload: acc1 drifts down by 1 per clock from 2F-1, acc2 pins at +max.
        do_reset();
        repeat (1000) step(64'sh7FFFFF);
        a1v = dut.acc1;
        a2v = dut.acc2;
        check("ovl_pos_acc1", a1v, 2 * F - 1000);
        check("ovl_pos_acc2", a2v, SAT_MAX);
        check("ovl_pos_dout", longint'(dout), 1);
        repeat (64) step(0);
        cnt = 0;
        repeat (128) begin
            step(0);
            cnt += longint'(dout);
        end
        check_range("ovl_pos_recover", cnt, 58, 70);

        // Negative overload at din = -F: acc1 settles at -2F, acc2 pins at -max.
        do_reset();
        repeat (40) step(-F);
        a1v = dut.acc1;
        a2v = dut.acc2;
        check("ovl_neg_acc1", a1v, -2 * F);
        check("ovl_neg_acc2", a2v, SAT_MIN);
        check("ovl_neg_dout", longint'(dout), 0);
        repeat (64) step(0);
        cnt = 0;
        repeat (128) begin
            step(0);
            cnt += longint'(dout);
        end
        check_range("ovl_neg_recover", cnt, 58, 70);

        // Mid-stream reset while dout = 1, released with din = 0.
        do_reset();
        repeat (100) step(64'sh400000);
        tries = 0;
        while (!m_dout && tries < 8) begin
            step(64'sh400000);
            tries++;
        end
        check("midrst_dout_high_before", longint'(dout), 1);
        #2;
        n_rst = 1'b0;
        din = '0;
        #1;
        model_reset();
        check("midrst_dout_async", longint'(dout), 0);
        a1v = dut.acc1;
        a2v = dut.acc2;
        check("midrst_acc1", a1v, 0);
        check("midrst_acc2", a2v, 0);
        @(negedge clk);
        check("midrst_dout_held", longint'(dout), 0);
        n_rst = 1'b1;
        run_seq0("seq_after_rst");

        // Half-scale sine, period 256: 256-tap average of dout tracks that of din.
        do_reset();
        sum_din = 0;
        sum_fb  = 0;
        max_err = 0;
        for (int i = 0; i < 256; i++) begin
            ring_din[i] = 0;
            ring_fb[i]  = 0;
        end
        for (int n = 0; n < 65536; n++) begin
            d = longint'($rtoi(0.5 * real'(F) * $sin(2.0 * 3.14159265358979 * real'(n) / 256.0)));
            step(d);
            idx = n % 256;
            sum_din += d - ring_din[idx];
            ring_din[idx] = d;
            sum_fb += (dout ? F : -F) - ring_fb[idx];
            ring_fb[idx] = dout ? F : -F;
            if (n >= 255) begin
                err = sum_din - sum_fb;
                if (err < 0) err = -err;
                if (err > max_err) max_err = err;
            end
        end
        check_range("sine_track_err_x256", max_err, 0, (F * 256 * 2) / 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
